io_bank_ctrl: RTL and testbench

IO_BANK_CTRL -- requirements
Module: io_bank_ctrl

---
 rtl/io_bank_pkg.sv | 44 ++++
 rtl/io_bank_chan.sv | 128 ++++++++++++
 rtl/io_bank_ctrl.sv | 138 +++++++++++++
 tb/tb_io_bank_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bank_pkg.sv
// io_bank_pkg -- shared types for the IO bank controller.
//   io_mode_t   : per-channel pad mode (INPUT, OUTPUT, OPEN_DRAIN, ALT)
//   cfg_state_t : configuration FSM states (IDLE, APPLY)
//   ch_idx_w()  : width of a channel index, never below 1 bit
//   pad_drive() : pad {oe, out} for a mode, level and core-side request
package io_bank_pkg;

  localparam logic [1:0] MODE_ENC_INPUT      = 2'd0;
  localparam logic [1:0] MODE_ENC_OUTPUT     = 2'd1;
  localparam logic [1:0] MODE_ENC_OPEN_DRAIN = 2'd2;
  localparam logic [1:0] MODE_ENC_ALT        = 2'd3;

  typedef enum logic [1:0] {
    MODE_INPUT      = MODE_ENC_INPUT,
    MODE_OUTPUT     = MODE_ENC_OUTPUT,
    MODE_OPEN_DRAIN = MODE_ENC_OPEN_DRAIN,
    MODE_ALT        = MODE_ENC_ALT
  } io_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } cfg_state_t;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns {oe, out}. Open drain only ever pulls low: releasing the line
  // (val=1) means turning the driver off.
  function automatic logic [1:0] pad_drive(input io_mode_t mode, input logic val,
                                           input logic c_out, input logic c_oe);
    logic [1:0] drv;
    case (mode)
      MODE_INPUT:      drv = 2'b00;
      MODE_OUTPUT:     drv = {1'b1, val};
      MODE_OPEN_DRAIN: drv = {~val, 1'b0};
      MODE_ALT:        drv = {c_oe, c_out};
      default:         drv = 2'b00;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/io_bank_chan.sv
// io_bank_chan -- one IO channel: mode/level/irq-enable registers, 2-flop
// input synchroniser, optional debounce, change detect and pending flag.
// Optional feature: IO_BANK_DEBOUNCE_EN adds a per-channel debounce counter.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   wr_en                       load wr_mode/wr_val/wr_irq_en this edge
//   wr_mode, wr_val, wr_irq_en  new configuration for this channel
//   db_thresh                   debounce threshold (ignored without debounce)
//   pad_in, pad_out, pad_oe     pad-cell side
//   core_out, core_oe, core_in  core side
//   irq_clear, irq_pending      pending flag clear / state
module io_bank_chan import io_bank_pkg::*; #(
  parameter int DB_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  io_mode_t        wr_mode,
  input  logic            wr_val,
  input  logic            wr_irq_en,
  input  logic [DB_W-1:0] db_thresh,
  input  logic            pad_in,
  input  logic            core_out,
  input  logic            core_oe,
  input  logic            irq_clear,
  output logic            pad_out,
  output logic            pad_oe,
  output logic            core_in,
  output logic            irq_pending
);

  io_mode_t mode_r;
  logic     val_r;
  logic     irq_en_r;
  logic     sync1_r;
  logic     sync2_r;
  logic     pend_r;
  logic     change_s;   // stable value flips on the coming edge
  logic     stable_s;

  // Channel configuration registers, loaded on the APPLY edge
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r   <= MODE_INPUT;
      val_r    <= 1'b0;
      irq_en_r <= 1'b0;
    end else if (wr_en) begin
      mode_r   <= wr_mode;
      val_r    <= wr_val;
      irq_en_r <= wr_irq_en;
    end else begin
      mode_r   <= mode_r;
      val_r    <= val_r;
      irq_en_r <= irq_en_r;
    end
  end

  // Two-flop synchroniser on the pad input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pad_in;
      sync2_r <= sync1_r;
    end
  end

`ifdef IO_BANK_DEBOUNCE_EN
  logic            stable_r;
  logic [DB_W-1:0] cnt_r;
  logic            cnt_hit_s;

  // The counter only runs while sync disagrees with stable, so reaching the
  // threshold means the new level persisted that long.
  assign cnt_hit_s = (cnt_r >= db_thresh);
  assign change_s  = (sync2_r != stable_r) && cnt_hit_s;
  assign stable_s  = stable_r;

  // Debounce counter (saturating) and stable value register
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else if (sync2_r == stable_r) begin
      stable_r <= stable_r;
      cnt_r    <= '0;
    end else if (cnt_hit_s) begin
      stable_r <= sync2_r;
      cnt_r    <= '0;
    end else if (cnt_r != {DB_W{1'b1}}) begin
      stable_r <= stable_r;
      cnt_r    <= cnt_r + DB_W'(1'b1);
    end else begin
      stable_r <= stable_r;
      cnt_r    <= cnt_r;
    end
  end
`else
  logic unused_db_s;

  // Stable is the synchroniser output; it flips on the edge sync1 moves into sync2.
  assign change_s    = sync1_r ^ sync2_r;
  assign stable_s    = sync2_r;
  assign unused_db_s = ^db_thresh;
`endif

  // Pending flag: disabling the interrupt drops it, a new change beats irq_clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= 1'b0;
    end else if (wr_en && !wr_irq_en) begin
      pend_r <= 1'b0;
    end else if (irq_en_r && change_s) begin
      pend_r <= 1'b1;
    end else if (irq_clear) begin
      pend_r <= 1'b0;
    end else begin
      pend_r <= pend_r;
    end
  end

  // ALT mode passes core_out/core_oe straight through to the pad.
  assign {pad_oe, pad_out} = pad_drive(mode_r, val_r, core_out, core_oe);
  assign core_in           = stable_s;
  assign irq_pending       = pend_r;

endmodule

// File: rtl/io_bank_ctrl.sv
// io_bank_ctrl -- bank of NUM_CH configurable bidirectional IO channels.
// A write (cfg_valid && cfg_ready) is captured, the FSM spends one APPLY
// cycle, and the target channel takes the new setting on the edge leaving
// APPLY. Writes to channels >= NUM_CH are accepted, change nothing and raise
// cfg_err during APPLY.
// Optional feature: IO_BANK_DEBOUNCE_EN enables per-channel input debounce.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cfg_valid/cfg_ready              write handshake
//   cfg_ch, cfg_mode, cfg_val,
//   cfg_irq_en                       write payload
//   cfg_err                          invalid-channel pulse
//   db_thresh                        global debounce threshold
//   pad_in/pad_out/pad_oe            pad-cell side
//   core_out/core_oe/core_in         core side
//   irq_pending/irq_clear, irq       per-channel pending flags, OR of them
module io_bank_ctrl import io_bank_pkg::*; #(
  parameter  int NUM_CH = 5,
  parameter  int DB_W   = 8,
  localparam int CH_W   = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_val,
  input  logic              cfg_irq_en,
  output logic              cfg_err,
  input  logic [DB_W-1:0]   db_thresh,
  input  logic [NUM_CH-1:0] pad_in,
  output logic [NUM_CH-1:0] pad_out,
  output logic [NUM_CH-1:0] pad_oe,
  input  logic [NUM_CH-1:0] core_out,
  input  logic [NUM_CH-1:0] core_oe,
  output logic [NUM_CH-1:0] core_in,
  output logic [NUM_CH-1:0] irq_pending,
  input  logic [NUM_CH-1:0] irq_clear,
  output logic              irq
);

  // One extra bit so NUM_CH itself is representable for the range check.
  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  cfg_state_t      state_r;
  cfg_state_t      state_nxt_s;
  logic            rdy_r;
  logic            err_r;
  logic            accept_s;
  logic            apply_s;
  logic            ch_bad_s;
  logic [CH_W-1:0] ch_r;
  io_mode_t        mode_r;
  logic            val_r;
  logic            irq_en_r;

  assign accept_s = cfg_valid && rdy_r;
  assign ch_bad_s = ({1'b0, cfg_ch} >= NUM_CH_V);
  assign apply_s  = (state_r == ST_APPLY);

  // Configuration FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_APPLY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_APPLY: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state plus registered ready/error; ready stays low through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      rdy_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rdy_r   <= (state_nxt_s == ST_IDLE);
      err_r   <= accept_s && ch_bad_s;
    end
  end

  // Capture the accepted write payload for the APPLY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_r     <= '0;
      mode_r   <= MODE_INPUT;
      val_r    <= 1'b0;
      irq_en_r <= 1'b0;
    end else if (accept_s) begin
      ch_r     <= cfg_ch;
      mode_r   <= io_mode_t'(cfg_mode);
      val_r    <= cfg_val;
      irq_en_r <= cfg_irq_en;
    end else begin
      ch_r     <= ch_r;
      mode_r   <= mode_r;
      val_r    <= val_r;
      irq_en_r <= irq_en_r;
    end
  end

  // An out-of-range ch_r matches no channel, so invalid writes change nothing.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    io_bank_chan #(
      .DB_W(DB_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (apply_s && (ch_r == CH_W'(gi))),
      .wr_mode     (mode_r),
      .wr_val      (val_r),
      .wr_irq_en   (irq_en_r),
      .db_thresh   (db_thresh),
      .pad_in      (pad_in[gi]),
      .core_out    (core_out[gi]),
      .core_oe     (core_oe[gi]),
      .irq_clear   (irq_clear[gi]),
      .pad_out     (pad_out[gi]),
      .pad_oe      (pad_oe[gi]),
      .core_in     (core_in[gi]),
      .irq_pending (irq_pending[gi])
    );
  end

  assign cfg_ready = rdy_r;
  assign cfg_err   = err_r;
  assign irq       = |irq_pending;

endmodule

// File: tb/tb_io_bank_ctrl.sv
// Self-checking bench for io_bank_ctrl (NUM_CH=5, DB_W=8). Expected values
// are pushed to a scoreboard queue as stimulus is driven and popped when the
// DUT output is sampled (#1 after the rising edge).
module tb_io_bank_ctrl;

  localparam int NUM_CH = 5;
  localparam int DB_W   = 8;
`ifdef IO_BANK_DEBOUNCE_EN
  localparam int IN_LAT = 3;  // db_thresh=0: sync stages plus stable register
`else
  localparam int IN_LAT = 2;  // sync stages only
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [1:0]        cfg_mode;
  logic              cfg_val;
  logic              cfg_irq_en;
  logic              cfg_err;
  logic [DB_W-1:0]   db_thresh;
  logic [NUM_CH-1:0] pad_in;
  logic [NUM_CH-1:0] pad_out;
  logic [NUM_CH-1:0] pad_oe;
  logic [NUM_CH-1:0] core_out;
  logic [NUM_CH-1:0] core_oe;
  logic [NUM_CH-1:0] core_in;
  logic [NUM_CH-1:0] irq_pending;
  logic [NUM_CH-1:0] irq_clear;
  logic              irq;

  always #5 clk = ~clk;

  io_bank_ctrl #(.NUM_CH(NUM_CH), .DB_W(DB_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_val(cfg_val),
    .cfg_irq_en(cfg_irq_en), .cfg_err(cfg_err), .db_thresh(db_thresh),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe),
    .core_out(core_out), .core_oe(core_oe), .core_in(core_in),
    .irq_pending(irq_pending), .irq_clear(irq_clear), .irq(irq)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] m_mode[NUM_CH];
  logic       m_val[NUM_CH];

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk_val("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk_val(e.tag, obs, e.exp);
    end
  endtask

  // Reference pad drive from the bench's own copy of the channel settings.
  function automatic logic [NUM_CH-1:0] m_oe();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) begin
      case (m_mode[i])
        2'd0:    v[i] = 1'b0;
        2'd1:    v[i] = 1'b1;
        2'd2:    v[i] = ~m_val[i];
        default: v[i] = core_oe[i];
      endcase
    end
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] m_out();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) begin
      case (m_mode[i])
        2'd0:    v[i] = 1'b0;
        2'd1:    v[i] = m_val[i];
        2'd2:    v[i] = 1'b0;
        default: v[i] = core_out[i];
      endcase
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_mode[i] = 2'd0;
      m_val[i]  = 1'b0;
    end
  endtask

  // One configuration write: accepted at the first edge, applied at the second.
  task automatic do_write(input int ch, input logic [1:0] mode, input logic val, input logic ien);
    logic ok;
    logic [31:0] chv;
    ok  = (ch < NUM_CH);
    chv = 32'(ch);
    cfg_valid  = 1'b1;
    cfg_ch     = chv[2:0];
    cfg_mode   = mode;
    cfg_val    = val;
    cfg_irq_en = ien;
    push_exp("wr_ready_pre", 32'd1);       pop_cmp(32'(cfg_ready));
    tick();
    cfg_valid = 1'b0;
    push_exp("apply_ready", 32'd0);        pop_cmp(32'(cfg_ready));
    push_exp("apply_err", ok ? 32'd0 : 32'd1); pop_cmp(32'(cfg_err));
    push_exp("apply_oe_old", 32'(m_oe())); pop_cmp(32'(pad_oe));
    if (ok) begin
      m_mode[ch] = mode;
      m_val[ch]  = val;
    end
    tick();
    push_exp("post_oe", 32'(m_oe()));      pop_cmp(32'(pad_oe));
    push_exp("post_out", 32'(m_out()));    pop_cmp(32'(pad_out));
    push_exp("post_ready", 32'd1);         pop_cmp(32'(cfg_ready));
    push_exp("post_err", 32'd0);           pop_cmp(32'(cfg_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 3'd0; cfg_mode = 2'd0; cfg_val = 1'b0;
    cfg_irq_en = 1'b0; db_thresh = 8'd0; pad_in = 5'd0; core_out = 5'd0;
    core_oe = 5'd0; irq_clear = 5'd0;
    model_reset();
    repeat (3) tick();

    // Reset state
    push_exp("rst_ready", 32'd0); pop_cmp(32'(cfg_ready));
    push_exp("rst_err", 32'd0);   pop_cmp(32'(cfg_err));
    push_exp("rst_oe", 32'd0);    pop_cmp(32'(pad_oe));
    push_exp("rst_out", 32'd0);   pop_cmp(32'(pad_out));
    push_exp("rst_pend", 32'd0);  pop_cmp(32'(irq_pending));
    push_exp("rst_irq", 32'd0);   pop_cmp(32'(irq));
    rst = 1'b0;
    tick();
    push_exp("rst_release_ready", 32'd1); pop_cmp(32'(cfg_ready));

    // OUTPUT, OPEN_DRAIN, invalid channel, ALT
    do_write(2, 2'd1, 1'b1, 1'b0);
    do_write(1, 2'd2, 1'b0, 1'b0);
    do_write(1, 2'd2, 1'b1, 1'b0);
    do_write(7, 2'd1, 1'b1, 1'b0);
    do_write(4, 2'd3, 1'b0, 1'b0);
    core_out = 5'b10010;
    core_oe  = 5'b10001;
    #1;
    push_exp("alt_oe", 32'(m_oe()));   pop_cmp(32'(pad_oe));
    push_exp("alt_out", 32'(m_out())); pop_cmp(32'(pad_out));

    // Interrupt on a rising input, then clear colliding with a falling input
    do_write(3, 2'd0, 1'b0, 1'b1);
    pad_in[3] = 1'b1;
    repeat (IN_LAT - 1) tick();
    push_exp("irq_early_pend", 32'd0); pop_cmp(32'(irq_pending));
    push_exp("irq_early_in", 32'd0);   pop_cmp(32'(core_in[3]));
    tick();
    push_exp("irq_rise_pend", 32'h08); pop_cmp(32'(irq_pending));
    push_exp("irq_rise_irq", 32'd1);   pop_cmp(32'(irq));
    push_exp("irq_rise_in", 32'd1);    pop_cmp(32'(core_in[3]));
    pad_in[3] = 1'b0;
    repeat (IN_LAT - 1) tick();
    irq_clear[3] = 1'b1;
    tick();
    push_exp("clr_vs_set_pend", 32'h08); pop_cmp(32'(irq_pending));
    push_exp("fall_in", 32'd0);          pop_cmp(32'(core_in[3]));
    tick();
    irq_clear[3] = 1'b0;
    push_exp("clr_pend", 32'd0); pop_cmp(32'(irq_pending));
    push_exp("clr_irq", 32'd0);  pop_cmp(32'(irq));

    // Disabling the interrupt drops a pending flag; enabling creates none
    pad_in[3] = 1'b1;
    repeat (IN_LAT) tick();
    push_exp("rearm_pend", 32'h08); pop_cmp(32'(irq_pending));
    do_write(3, 2'd0, 1'b0, 1'b0);
    push_exp("dis_pend", 32'd0); pop_cmp(32'(irq_pending));
    do_write(3, 2'd0, 1'b0, 1'b1);
    push_exp("en_pend", 32'd0); pop_cmp(32'(irq_pending));

`ifdef IO_BANK_DEBOUNCE_EN
    // Debounce: a 2-cycle glitch is filtered, a sustained level passes
    db_thresh = 8'd3;
    pad_in[0] = 1'b1;
    repeat (2) tick();
    pad_in[0] = 1'b0;
    repeat (8) tick();
    push_exp("db_glitch_in", 32'd0); pop_cmp(32'(core_in[0]));
    pad_in[0] = 1'b1;
    repeat (5) tick();
    push_exp("db_hold5_in", 32'd0); pop_cmp(32'(core_in[0]));
    tick();
    push_exp("db_hold6_in", 32'd1); pop_cmp(32'(core_in[0]));
    db_thresh = 8'd0;
`else
    // No debounce: the threshold is ignored and the input lags two edges
    db_thresh = 8'hff;
    pad_in[0] = 1'b1;
    tick();
    push_exp("sync1_in", 32'd0); pop_cmp(32'(core_in[0]));
    tick();
    push_exp("sync2_in", 32'd1); pop_cmp(32'(core_in[0]));
    db_thresh = 8'd0;
`endif

    // Reset in the middle of an APPLY: the write must leave no trace
    pad_in = 5'd0;
    repeat (4) tick();
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_mode = 2'd1; cfg_val = 1'b1; cfg_irq_en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    push_exp("mid_apply_ready", 32'd0); pop_cmp(32'(cfg_ready));
    rst = 1'b1;
    tick();
    model_reset();
    push_exp("abort_ready", 32'd0); pop_cmp(32'(cfg_ready));
    push_exp("abort_oe", 32'd0);    pop_cmp(32'(pad_oe));
    push_exp("abort_out", 32'd0);   pop_cmp(32'(pad_out));
    push_exp("abort_pend", 32'd0);  pop_cmp(32'(irq_pending));
    push_exp("abort_irq", 32'd0);   pop_cmp(32'(irq));
    push_exp("abort_in", 32'd0);    pop_cmp(32'(core_in));
    rst = 1'b0;
    tick();
    push_exp("abort_release_ready", 32'd1); pop_cmp(32'(cfg_ready));
    push_exp("abort_release_oe", 32'(m_oe())); pop_cmp(32'(pad_oe));
    do_write(0, 2'd1, 1'b1, 1'b0);

    chk_val("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
